// File: rtl/fifo_ctrl.sv
// Pointer/flag controller for a FIFO on the DRAM1 dual-port memory (A = write, B = read).
// Build option FIFO_ERR_STICKY_EN: overflow/underflow hold until reset instead of pulsing.
module fifo_ctrl #(
    parameter int DATA_WIDTH   = 4,
    parameter int ADDR_WIDTH   = 3,
    parameter int ALMOST_FULL  = 6,
    parameter int ALMOST_EMPTY = 2
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [DATA_WIDTH-1:0] q_b,
    output logic [DATA_WIDTH-1:0] data_a,
    output logic [ADDR_WIDTH-1:0] addr_a,
    output logic                  we_a,
    output logic [ADDR_WIDTH-1:0] addr_b,
    output logic                  re_b,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(1 << ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(ALMOST_FULL);
    localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(ALMOST_EMPTY);

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  push_acc;
    logic                  pop_acc;
    logic [ADDR_WIDTH:0]   count_nxt;
    logic                  overflow_nxt;
    logic                  underflow_nxt;

    // Full/empty are registered, so acceptance never depends on this cycle's request mix.
    always_comb begin
        push_acc = push & ~full;
        pop_acc  = pop & ~empty;
    end

    always_comb begin
        count_nxt = count;
        unique case ({push_acc, pop_acc})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

`ifdef FIFO_ERR_STICKY_EN
    always_comb begin
        overflow_nxt  = overflow  | (push & full);
        underflow_nxt = underflow | (pop & empty);
    end
`else
    always_comb begin
        overflow_nxt  = push & full;
        underflow_nxt = pop & empty;
    end
`endif

    // Enables are gated by reset so DRAM1 sees no access while the pointers are being cleared.
    assign we_a     = reset_L & push_acc;
    assign re_b     = reset_L & pop_acc;
    assign addr_a   = wr_ptr;
    assign addr_b   = rd_ptr;
    assign data_a   = data_in;
    assign data_out = q_b;

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            valid_out    <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (push_acc) wr_ptr <= wr_ptr + 1'b1;
            if (pop_acc)  rd_ptr <= rd_ptr + 1'b1;
            count        <= count_nxt;
            full         <= (count_nxt == DEPTH_C);
            empty        <= (count_nxt == '0);
            almost_full  <= (count_nxt >= AF_C);
            almost_empty <= (count_nxt <= AE_C);
            valid_out    <= pop_acc;
            overflow     <= overflow_nxt;
            underflow    <= underflow_nxt;
        end
    end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl: behavioural DRAM1 on the memory ports, queue scoreboard for data.
module tb_fifo_ctrl;

    localparam int DW = 4;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          reset_L = 1'b0;
    logic          push = 1'b0;
    logic          pop = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] q_b = '0;
    logic [DW-1:0] data_a;
    logic [AW-1:0] addr_a;
    logic          we_a;
    logic [AW-1:0] addr_b;
    logic          re_b;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic [AW:0]   count;
    logic          full, empty, almost_full, almost_empty, overflow, underflow;

    fifo_ctrl dut (
        .clk(clk), .reset_L(reset_L), .push(push), .pop(pop), .data_in(data_in),
        .q_b(q_b), .data_a(data_a), .addr_a(addr_a), .we_a(we_a), .addr_b(addr_b),
        .re_b(re_b), .data_out(data_out), .valid_out(valid_out), .count(count),
        .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    // DRAM1 stand-in: registered read, one clk after re_b.
    logic [DW-1:0] mem [8];
    always @(posedge clk) begin
        if (we_a) mem[addr_a] <= data_a;
        if (re_b) q_b <= mem[addr_b];
    end

    int n_vec = 0;
    int n_err = 0;

    logic [DW-1:0] sb[$];
    int            m_cnt = 0;
    logic [AW-1:0] m_wr = '0;
    logic [AW-1:0] m_rd = '0;
    logic          m_ovf = 1'b0;
    logic          m_unf = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input logic p, input logic q, input logic [DW-1:0] d);
        logic          pa, qa;
        logic [DW-1:0] exp_d;
        exp_d = '0;
        @(negedge clk);
        push = p; pop = q; data_in = d;
        #1;
        pa = p && (m_cnt != 8);
        qa = q && (m_cnt != 0);
        chk("we_a", 32'(we_a), 32'(pa));
        chk("re_b", 32'(re_b), 32'(qa));
        if (pa) begin
            chk("addr_a", 32'(addr_a), 32'(m_wr));
            chk("data_a", 32'(data_a), 32'(d));
        end
        if (qa) chk("addr_b", 32'(addr_b), 32'(m_rd));
`ifdef FIFO_ERR_STICKY_EN
        m_ovf = m_ovf | (p && m_cnt == 8);
        m_unf = m_unf | (q && m_cnt == 0);
`else
        m_ovf = p && m_cnt == 8;
        m_unf = q && m_cnt == 0;
`endif
        if (qa) begin
            exp_d = sb.pop_front();
            m_rd++;
        end
        if (pa) begin
            sb.push_back(d);
            m_wr++;
        end
        m_cnt = m_cnt + int'(pa) - int'(qa);
        @(posedge clk);
        #1;
        chk("count", 32'(count), 32'(m_cnt));
        chk("full", 32'(full), 32'(m_cnt == 8));
        chk("empty", 32'(empty), 32'(m_cnt == 0));
        chk("almost_full", 32'(almost_full), 32'(m_cnt >= 6));
        chk("almost_empty", 32'(almost_empty), 32'(m_cnt <= 2));
        chk("valid_out", 32'(valid_out), 32'(qa));
        if (qa) chk("data_out", 32'(data_out), 32'(exp_d));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("underflow", 32'(underflow), 32'(m_unf));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_L = 1'b0; push = 1'b1; pop = 1'b1;
        #1;
        chk("rst_we_a", 32'(we_a), 32'd0);
        chk("rst_re_b", 32'(re_b), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_almost_empty", 32'(almost_empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_almost_full", 32'(almost_full), 32'd0);
        chk("rst_valid_out", 32'(valid_out), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_underflow", 32'(underflow), 32'd0);
        @(negedge clk);
        reset_L = 1'b1; push = 1'b0; pop = 1'b0;
        sb.delete();
        m_cnt = 0; m_wr = '0; m_rd = '0; m_ovf = 1'b0; m_unf = 1'b0;
        #1;
        chk("rst_addr_a", 32'(addr_a), 32'd0);
        chk("rst_addr_b", 32'(addr_b), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset then idle
        do_reset();
        step(1'b0, 1'b0, '0);

        // 2: fill with 1..8, then push into full
        for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, DW'(i));
        step(1'b1, 1'b0, 4'h9);
        step(1'b0, 1'b0, '0);

        // 3: drain, then pop from empty
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, '0);
        step(1'b0, 1'b1, '0);
        step(1'b0, 1'b0, '0);

        // 4: wrap-around from a fresh reset
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, DW'(4'hA + i));
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, '0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, DW'($urandom_range(0, 15)));
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, '0);

        // 5: simultaneous push+pop at 3, at 0 and at 8
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, DW'(3 + i));
        step(1'b1, 1'b1, 4'hC);
        step(1'b1, 1'b1, 4'hD);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, '0);
        step(1'b1, 1'b1, 4'h5);
        step(1'b0, 1'b1, '0);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, DW'($urandom_range(0, 15)));
        step(1'b1, 1'b1, 4'hE);
        step(1'b0, 1'b0, '0);

        // 6: overflow, drain to 5, reset mid-traffic
        step(1'b1, 1'b0, 4'h7);
        step(1'b1, 1'b0, 4'h8);
        step(1'b0, 1'b1, '0);
        step(1'b0, 1'b1, '0);
        step(1'b0, 1'b1, '0);
        chk("pre_reset_count", 32'(count), 32'd5);
        do_reset();
        step(1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 4'h3);
        step(1'b0, 1'b1, '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
